// File: rtl/core_wb_stage.sv
// Execute/writeback stage register: holds one instruction from ID, selects the
// writeback source, waits on multi-cycle loads with timeout, and counts retirements.
module core_wb_stage #(
  parameter  int XLEN        = 32,
  parameter  int NREGS       = 16,
  parameter  int ZERO_REG    = 0,
  parameter  int MEM_TIMEOUT = 64,
  parameter  int CNT_W       = 32,
  localparam int AW          = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [AW-1:0]    id_rd,
  input  logic [1:0]       id_wb_sel,
  input  logic             flush,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  rega_data,
  input  logic             mau_valid,
  input  logic [XLEN-1:0]  mau_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             mem_err
);

  typedef enum logic [1:0] {EMPTY, HOLD, WAIT_MEM} state_e;

  localparam int            TW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q;
  logic [AW-1:0]    rd_q;
  logic [1:0]       sel_q;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] retire_q;
  logic             mem_err_q;

  logic             done;
  logic             timeout;
  logic             wr_req;
  logic [XLEN-1:0]  wr_src;
  logic             accept;

  always_comb begin
    id_ready = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    wr_req   = 1'b0;
    wr_src   = '0;
    case (state_q)
      EMPTY: id_ready = !flush;
      HOLD: begin
        id_ready = !flush;
        done     = !flush && !rst;
        // sel 1 and 3 write, sel 0 does not; loads never sit in HOLD
        wr_req   = sel_q[0];
        wr_src   = (sel_q == 2'd3) ? rega_data : alu_result;
      end
      WAIT_MEM: begin
        id_ready = !flush && mau_valid;
        done     = !flush && !rst && mau_valid;
        wr_req   = 1'b1;
        wr_src   = mau_data;
        timeout  = (MEM_TIMEOUT != 0) && !flush && !mau_valid && (tmo_q == TLAST);
      end
      default: ;
    endcase
    accept  = id_valid && id_ready;
    wb_en   = done && wr_req && !((ZERO_REG != 0) && (rd_q == '0));
    wb_data = wb_en ? wr_src : '0;
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    if (flush || timeout) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = (id_wb_sel == 2'd2) ? WAIT_MEM : HOLD;
      tmo_d   = '0;
    end else if (done) begin
      state_d = EMPTY;
    end else if (state_q == WAIT_MEM) begin
      tmo_d   = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      pc_q      <= '0;
      rd_q      <= '0;
      sel_q     <= '0;
      tmo_q     <= '0;
      retire_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= timeout;
      if (done) retire_q <= retire_q + CNT_W'(1);
      if (accept && !flush) begin
        pc_q  <= id_pc;
        rd_q  <= id_rd;
        sel_q <= id_wb_sel;
      end
    end
  end

  assign ex_valid   = (state_q != EMPTY);
  assign ex_pc      = pc_q;
  assign wb_addr    = ex_valid ? rd_q : '0;
  assign retire_cnt = retire_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_core_wb_stage.sv
// Scoreboard bench for core_wb_stage: a transaction-level model predicts each
// cycle's status and every register write; a monitor compares at the falling edge.
module tb_core_wb_stage;
  localparam int XLEN = 32;
  localparam int AW   = 4;
  localparam int CW   = 4;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            id_valid = 1'b0;
  logic            id_ready;
  logic [XLEN-1:0] id_pc = '0;
  logic [AW-1:0]   id_rd = '0;
  logic [1:0]      id_wb_sel = '0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] alu_result = '0;
  logic [XLEN-1:0] rega_data = '0;
  logic            mau_valid = 1'b0;
  logic [XLEN-1:0] mau_data = '0;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [CW-1:0]   retire_cnt;
  logic            mem_err;

  always #5 clk = ~clk;

  core_wb_stage #(
    .XLEN(XLEN), .NREGS(16), .ZERO_REG(1), .MEM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rd(id_rd), .id_wb_sel(id_wb_sel), .flush(flush),
    .alu_result(alu_result), .rega_data(rega_data), .mau_valid(mau_valid),
    .mau_data(mau_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .retire_cnt(retire_cnt), .mem_err(mem_err)
  );

  typedef struct {
    int unsigned     cyc;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  typedef struct {
    bit              skip;
    bit              ready;
    bit              exv;
    logic [XLEN-1:0] pc;
    logic [AW-1:0]   addr;
    logic [CW-1:0]   ret;
    bit              err;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  checks = 0;
  int  errors = 0;
  int unsigned cyc  = 0;
  int unsigned mcyc = 0;

  // Reference model: one resident instruction, how long it has waited, total retired.
  bit              m_busy = 0, m_load = 0, m_err = 0;
  logic [XLEN-1:0] m_pc = '0;
  logic [AW-1:0]   m_rd = '0;
  logic [1:0]      m_sel = '0;
  int              m_wait = 0;
  int unsigned     m_retired = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, mcyc, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input logic [XLEN-1:0] pc,
                       input logic [AW-1:0] rd, input logic [1:0] sel, input bit mv,
                       input logic [XLEN-1:0] md, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] rg);
    st_t s;
    wr_t w;
    bit  done, tout, rdy;
    @(posedge clk); #1;
    rst = r; flush = f; id_valid = v; id_pc = pc; id_rd = rd; id_wb_sel = sel;
    mau_valid = mv; mau_data = md; alu_result = alu; rega_data = rg;
    s = '{default: 0};
    s.skip = r;
    if (r) begin
      m_busy = 0; m_err = 0; m_retired = 0; m_pc = '0;
    end else begin
      rdy  = !f && (!m_busy || !m_load || mv);
      done = !f && m_busy && (!m_load || mv);
      tout = !f && m_busy && m_load && !mv && (m_wait == TMO - 1);
      s.ready = rdy; s.exv = m_busy; s.pc = m_pc;
      s.addr = m_busy ? m_rd : '0;
      s.ret  = CW'(m_retired);
      s.err  = m_err;
      if (done && m_sel != 2'd0 && m_rd != '0) begin
        w.cyc = cyc; w.addr = m_rd;
        w.data = m_load ? md : (m_sel == 2'd1 ? alu : rg);
        wq.push_back(w);
      end
      m_err = tout;
      if (f || tout) m_busy = 0;
      else begin
        if (done) begin m_retired++; m_busy = 0; end
        else if (m_busy && m_load) m_wait++;
        if (v && rdy) begin
          m_busy = 1; m_load = (sel == 2'd2); m_pc = pc; m_rd = rd; m_sel = sel; m_wait = 0;
        end
      end
    end
    sq.push_back(s);
    cyc++;
  endtask

  task automatic idle(input int n, input bit mv);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 2'd0, mv, $urandom, $urandom, $urandom);
  endtask

  initial begin : monitor
    st_t s;
    wr_t w;
    bit  exp_en;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        if (!s.skip) begin
          chk("id_ready", 64'(id_ready), 64'(s.ready));
          chk("ex_valid", 64'(ex_valid), 64'(s.exv));
          chk("wb_addr", 64'(wb_addr), 64'(s.addr));
          chk("retire_cnt", 64'(retire_cnt), 64'(s.ret));
          chk("mem_err", 64'(mem_err), 64'(s.err));
          if (s.exv) chk("ex_pc", 64'(ex_pc), 64'(s.pc));
          exp_en = (wq.size() > 0) && (wq[0].cyc == mcyc);
          chk("wb_en", 64'(wb_en), 64'(exp_en));
          if (exp_en) begin
            w = wq.pop_front();
            if (wb_en) chk("wb_data", 64'(wb_data), 64'(w.data));
          end else begin
            chk("wb_data_idle", 64'(wb_data), 64'd0);
          end
        end
        mcyc++;
      end
    end
  end

  initial begin : stimulus
    drive(1, 0, 0, '0, '0, 2'd0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, 2'd0, 0, '0, '0, '0);
    // ALU stream, each result presented in its resident cycle
    drive(0, 0, 1, 32'h100, 4'd1, 2'd1, 0, '0, 32'h0,  '0);
    drive(0, 0, 1, 32'h104, 4'd2, 2'd1, 0, '0, 32'h11, '0);
    drive(0, 0, 1, 32'h108, 4'd3, 2'd1, 0, '0, 32'h22, '0);
    drive(0, 0, 0, '0, '0, 2'd0, 0, '0, 32'h33, '0);
    // load stall with a queued mov accepted in the response cycle
    drive(0, 0, 1, 32'h200, 4'd5, 2'd2, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'h204, 4'd7, 2'd3, 0, '0, '0, '0);
    drive(0, 0, 1, 32'h204, 4'd7, 2'd3, 1, 32'hDEADBEEF, '0, '0);
    drive(0, 0, 0, '0, '0, 2'd0, 0, '0, '0, 32'h5A5A5A5A);
    // lost load
    drive(0, 0, 1, 32'h300, 4'd6, 2'd2, 0, '0, '0, '0);
    idle(11, 0);
    // flush colliding with a response, then a late response
    drive(0, 0, 1, 32'h400, 4'd8, 2'd2, 0, '0, '0, '0);
    idle(2, 0);
    drive(0, 1, 1, 32'h404, 4'd9, 2'd1, 1, 32'hCAFEF00D, '0, '0);
    idle(1, 0);
    idle(1, 1);
    // write to r0 suppressed but retired
    drive(0, 0, 1, 32'h500, 4'd0, 2'd1, 0, '0, '0, '0);
    idle(1, 0);
    // reset while waiting on memory, then a stray response
    drive(0, 0, 1, 32'h600, 4'd4, 2'd2, 0, '0, '0, '0);
    idle(2, 0);
    drive(1, 0, 0, '0, '0, 2'd0, 0, '0, '0, '0);
    idle(1, 1);
    idle(1, 0);
    // randomized traffic; retire_cnt wraps at 16
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 70,
            $urandom, AW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 25, $urandom, $urandom, $urandom);
    idle(12, 0);
    @(negedge clk); #1;
    chk("status_queue_drained", 64'(sq.size()), 64'd0);
    chk("write_queue_drained", 64'(wq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_wb_stage.md
Name: core_wb_stage

Overview:
- Parametrised execute/writeback stage register. Holds one decoded instruction from ID behind a valid/ready handshake.
- Selects the writeback source (ALU result, memory data, or register-A move) and drives the register-file write port.
- Unlike the fixed single-cycle stage, it waits for a multi-cycle memory response, supports flush, times out lost loads, and counts retired instructions.

Parameters:
- XLEN, 32, data and PC width.
- NREGS, 16, number of architectural registers. AW = clog2(NREGS).
- ZERO_REG, 0, when 1, writes to register 0 are suppressed; the instruction still retires.
- MEM_TIMEOUT, 64, maximum WAIT_MEM cycles before abandoning a load. 0 disables the timeout.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage can accept this cycle.
- id_pc  in  XLEN  PC of the offered instruction.
- id_rd  in  AW  destination register.
- id_wb_sel  in  2  writeback source: 0 none, 1 ALU, 2 MEM (load), 3 REGA (mov).
- flush  in  1  kill the resident instruction and block accept.
- alu_result  in  XLEN  ALU output for the resident instruction.
- rega_data  in  XLEN  operand A for the resident instruction.
- mau_valid  in  1  memory response valid.
- mau_data  in  XLEN  memory response data.
- ex_valid  out  1  stage occupied.
- ex_pc  out  XLEN  PC of the resident instruction.
- wb_en  out  1  register-file write strobe.
- wb_addr  out  AW  write address (the resident rd).
- wb_data  out  XLEN  write data.
- retire_cnt  out  CNT_W  count of retired instructions.
- mem_err  out  1  one-cycle pulse on a load timeout.

Behaviour:
- State machine: EMPTY, HOLD (non-load resident), WAIT_MEM (load resident). Registered: state, pc, rd, sel, timeout counter, retire_cnt, mem_err.
- Accept: a transfer occurs on any edge where id_valid & id_ready. The next state is WAIT_MEM if sel==2, otherwise HOLD.
- id_ready = !flush & (state==EMPTY | state==HOLD | (state==WAIT_MEM & mau_valid)). A completing instruction is replaced in the same cycle, giving back-to-back throughput of 1/cycle.
- HOLD completes in its first resident cycle:
  - sel 1: wb_en=1, wb_data=alu_result.
  - sel 3: wb_en=1, wb_data=rega_data.
  - sel 0: wb_en=0.
  - The instruction retires. Next state is the new instruction if one is accepted, else EMPTY.
- WAIT_MEM:
  - Completes in the cycle mau_valid=1: wb_en=1, wb_data=mau_data, retire.
  - Otherwise wb_en=0. The counter starts at 0 on entry and increments each waiting cycle.
  - Timeout: if MEM_TIMEOUT!=0, counter==MEM_TIMEOUT-1 and !mau_valid, then mem_err pulses high on the next cycle, the stage goes to EMPTY, there is no writeback, and retire_cnt is unchanged.
  - mau_valid while in EMPTY or HOLD is ignored.
- wb_addr = resident rd whenever ex_valid. wb_data = 0 when wb_en=0.
- ZERO_REG=1 and rd==0: wb_en forced 0; retirement still counted.
- wb_en, wb_addr and wb_data are combinational from state and inputs. The resident instruction's result is therefore visible in its resident cycle (ALU/REGA) or its response cycle (MEM).
- ex_valid = (state!=EMPTY). ex_pc holds the resident PC and is held unchanged while in WAIT_MEM.
- Flush:
  - wb_en is forced 0 in the flush cycle.
  - No retire, no accept; next state is EMPTY.
  - A mau_valid arriving in the same cycle is discarded. A late response after the flush is ignored (stage is EMPTY or HOLD).
- retire_cnt increments by 1 per retirement and wraps modulo 2^CNT_W.
- Priority: rst > flush > timeout > completion/accept.
- Reset mid-operation, including in WAIT_MEM, abandons the instruction silently. Reset values: state EMPTY, ex_valid 0, ex_pc 0, wb_en 0, wb_addr 0, wb_data 0, retire_cnt 0, mem_err 0, timeout counter 0.

Test Plan:
- ALU stream: 3 back-to-back sel=1 instructions (rd 1,2,3), alu_result 0x11/0x22/0x33 in their resident cycles -> wb_en high 3 consecutive cycles with matching addr/data; id_ready stays 1; retire_cnt=3.
- Load stall: sel=2, rd=5; mau_valid after 4 cycles with 0xDEADBEEF -> id_ready=0 for the 4 wait cycles; single wb_en with addr 5, data 0xDEADBEEF; a queued sel=3 instruction is accepted in the response cycle.
- Timeout: MEM_TIMEOUT=8, load with no response -> mem_err pulses exactly once, 8 cycles after entry; no wb_en; retire_cnt unchanged; stage EMPTY, id_ready=1.
- Flush: flush asserted during WAIT_MEM in the same cycle mau_valid=1 -> wb_en=0, no retire, ex_valid=0 next cycle; id_valid in the flush cycle not accepted.
- ZERO_REG=1: sel=1, rd=0 -> wb_en=0, retire_cnt increments. Separately, CNT_W=4 with 17 retirements -> retire_cnt=1.
- Reset in WAIT_MEM: rst held 1 cycle -> all outputs at reset values next cycle; a subsequent mau_valid causes no write.
